// File: rtl/proc_control.sv
// Instruction sequencer for the 16-bit simple processor.
// Fetches an instruction from din, then walks it through T-states while
// driving the bus-source select, load enables, ALU op and memory strobe.
//
// state | meaning
// T0    | idle / fetch; run=1 loads IR from din
// T1    | first execute step (all opcodes)
// T2    | second step: add/sub ALU, st write, ld memory wait
// T3    | final write-back for add/sub and ld
module proc_control #(
  parameter int DATA_W   = 16,
  parameter int MEM_WAIT = 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              run,
  input  logic [DATA_W-1:0] din,
  input  logic              g_nz,
  output logic [10:0]       bus_sel,
  output logic              ir_in,
  output logic [7:0]        r_in,
  output logic              a_in,
  output logic              g_in,
  output logic [1:0]        alu_op,
  output logic              addr_in,
  output logic              mem_we,
  output logic              done
);

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} state_t;

  localparam logic [3:0] OP_MV   = 4'd0;
  localparam logic [3:0] OP_MVI  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_LD   = 4'd4;
  localparam logic [3:0] OP_ST   = 4'd5;
  localparam logic [3:0] OP_MVNZ = 4'd6;

  localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT);

  localparam int SEL_DIN = 0;
  localparam int SEL_G   = 9;
  localparam int SEL_MEM = 10;

  state_t     state_q, state_d;
  // Only the opcode/rx/ry fields (din[15:6]) are kept; the low six bits are don't-care.
  logic [9:0] ir_q, ir_d;
  logic [2:0] wait_q, wait_d;

  logic [3:0] opcode;
  logic [2:0] rx, ry;
  logic       unused_din;

  assign opcode     = ir_q[9:6];
  assign rx         = ir_q[5:3];
  assign ry         = ir_q[2:0];
  assign unused_din = ^din;

  // State, IR and ld wait counter registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= T0;
      ir_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state, IR capture and wait counter sequencing
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    wait_d  = wait_q;
    case (state_q)
      T0: begin
        if (run) begin
          ir_d    = din[15:6];
          state_d = T1;
        end
      end
      T1: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_ST: state_d = T2;
          OP_LD: begin
            wait_d  = WAIT_INIT;
            state_d = (MEM_WAIT == 0) ? T3 : T2;
          end
          default: state_d = T0;
        endcase
      end
      T2: begin
        case (opcode)
          OP_ADD, OP_SUB: state_d = T3;
          // Counter loaded with MEM_WAIT gives exactly MEM_WAIT idle cycles in T2.
          OP_LD: begin
            if (wait_q <= 3'd1) begin
              wait_d  = '0;
              state_d = T3;
            end else begin
              wait_d = wait_q - 3'd1;
            end
          end
          default: state_d = T0;
        endcase
      end
      default: state_d = T0;
    endcase
  end

  // Output decode; everything held low while reset is asserted
  always_comb begin
    bus_sel = '0;
    ir_in   = 1'b0;
    r_in    = '0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    alu_op  = 2'b00;
    addr_in = 1'b0;
    mem_we  = 1'b0;
    done    = 1'b0;
    if (resetn) begin
      case (state_q)
        T0: begin
          if (run) begin
            bus_sel[SEL_DIN] = 1'b1;
            ir_in            = 1'b1;
          end
        end
        T1: begin
          case (opcode)
            OP_MV: begin
              bus_sel[{1'b0, ry} + 4'd1] = 1'b1;
              r_in[rx]                   = 1'b1;
              done                       = 1'b1;
            end
            OP_MVI: begin
              bus_sel[SEL_DIN] = 1'b1;
              r_in[rx]         = 1'b1;
              done             = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              bus_sel[{1'b0, rx} + 4'd1] = 1'b1;
              a_in                       = 1'b1;
            end
            OP_LD, OP_ST: begin
              bus_sel[{1'b0, ry} + 4'd1] = 1'b1;
              addr_in                    = 1'b1;
            end
            OP_MVNZ: begin
              if (g_nz) begin
                bus_sel[{1'b0, ry} + 4'd1] = 1'b1;
                r_in[rx]                   = 1'b1;
              end
              done = 1'b1;
            end
            default: done = 1'b1;
          endcase
        end
        T2: begin
          case (opcode)
            OP_ADD, OP_SUB: begin
              bus_sel[{1'b0, ry} + 4'd1] = 1'b1;
              g_in                       = 1'b1;
              alu_op                     = (opcode == OP_SUB) ? 2'b01 : 2'b00;
            end
            OP_ST: begin
              bus_sel[{1'b0, rx} + 4'd1] = 1'b1;
              mem_we                     = 1'b1;
              done                       = 1'b1;
            end
            default: ;
          endcase
        end
        T3: begin
          case (opcode)
            OP_ADD, OP_SUB: begin
              bus_sel[SEL_G] = 1'b1;
              r_in[rx]       = 1'b1;
              done           = 1'b1;
            end
            OP_LD: begin
              bus_sel[SEL_MEM] = 1'b1;
              r_in[rx]         = 1'b1;
              done             = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule
